// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: shares one combinational adder among NREQ requesters.
// A round-robin arbiter picks one requester per operation; the adder result is
// registered and returned with the requester id on a valid/ready response port.
// The result register is a one-entry buffer that can be refilled in the same
// cycle it is drained, giving one operation per cycle under full load.

// Shared datapath: a + b + cin with the carry kept as a separate output.
module adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   // Extend every operand to WIDTH+1 bits so the carry-out is never truncated.
   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   end

endmodule

module adder_rr_scheduler #(
   parameter  int WIDTH = 8,
   parameter  int NREQ  = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_cin,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_s,
   output logic                  rsp_cout
);

   typedef enum logic {
      IDLE = 1'b0,   // no result held
      FULL = 1'b1    // result registers hold an unconsumed result
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDW-1:0]   ptr;          // highest-priority requester for the next grant
   logic [IDW-1:0]   ptr_next;
   logic [IDW-1:0]   grant_idx;
   logic             grant_found;
   logic             can_accept;
   logic             xfer;
   logic [IDW-1:0]   cand_idx;
   int               cand;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_cin;
   logic [WIDTH-1:0] sum;
   logic             sum_cout;

   // Round-robin search: first valid requester starting at ptr, wrapping at NREQ.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no
      // path leaves a variable unassigned and no latch is inferred.
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         // NOTE: blocking assignments here because cand/cand_idx are consumed
         // immediately within the same loop iteration.
         cand = int'(ptr) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = IDW'(cand);
         if (!grant_found && req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // A new result can be taken when nothing is held or the held one leaves now.
   assign can_accept = (state == IDLE) || ((state == FULL) && rsp_ready);

   // Transfer happens only for the granted requester; the grant already implies
   // req_valid, and reset blocks any acceptance in the same cycle.
   assign xfer = grant_found && can_accept && !rst;

   // Ready is one-hot on the granted requester; it never looks at operand data.
   always_comb begin
      req_ready = '0;
      if (xfer) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Steer the granted requester's operands into the shared adder.
   always_comb begin
      op_a   = '0;
      op_b   = '0;
      op_cin = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            op_a   = req_a[i*WIDTH +: WIDTH];
            op_b   = req_b[i*WIDTH +: WIDTH];
            op_cin = req_cin[i];
         end
      end
   end

   adder #(.WIDTH(WIDTH)) u_adder (
      .a    (op_a),
      .b    (op_b),
      .cin  (op_cin),
      .s    (sum),
      .cout (sum_cout)
   );

   // Priority moves to the requester just after the one that was served.
   assign ptr_next = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

   // Next-state logic for the one-entry result buffer.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (xfer) begin
               state_next = FULL;
            end
         end
         FULL: begin
            // Drained with nothing to replace it: go empty. Drained and refilled,
            // or stalled by the consumer: stay full.
            if (rsp_ready && !xfer) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register and arbitration pointer.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples values from before the edge, independent of statement order.
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_next;
         if (xfer) begin
            ptr <= ptr_next;
         end
      end
   end

   // Result registers: loaded on every transfer, otherwise held (also when idle).
   always_ff @(posedge clk) begin
      // NOTE: these datapath registers are reset because their reset values are
      // visible on the response port; pure pipeline data would not need it.
      if (rst) begin
         rsp_s    <= '0;
         rsp_cout <= 1'b0;
         rsp_id   <= '0;
      end else if (xfer) begin
         rsp_s    <= sum;
         rsp_cout <= sum_cout;
         rsp_id   <= grant_idx;
      end
   end

   assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler (WIDTH=8, NREQ=4).
// The driver keeps a behavioural model of the arbiter (pending requesters, a
// priority pointer and a result-held flag), checks req_ready/rsp_valid every
// cycle and pushes the expected response into a scoreboard queue. A separate
// monitor pops and compares whenever the DUT hands a response over.
module tb_adder_rr_scheduler;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_cin;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_s;
   logic                  rsp_cout;

   adder_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_s     (rsp_s),
      .rsp_cout  (rsp_cout)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int id;
      int sum;   // full a+b+cin, i.e. {cout, s}
   } exp_t;

   exp_t exp_q[$];

   // Requester model: an operation stays pending (and stable) until accepted.
   bit pend_v[NREQ];
   int pa[NREQ];
   int pb[NREQ];
   bit pc[NREQ];

   // Arbiter model state.
   bit model_full;
   int model_ptr;

   logic [NREQ-1:0] got;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_op(input int i, input int a, input int b, input bit c);
      pend_v[i] = 1'b1;
      pa[i]     = a;
      pb[i]     = b;
      pc[i]     = c;
   endtask

   task automatic gen_ops(input int pct);
      for (int i = 0; i < NREQ; i++) begin
         if (!pend_v[i] && int'($urandom_range(99)) < pct) begin
            set_op(i, int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom_range(1)));
         end
      end
   endtask

   // One clock cycle: drive at the falling edge, check against the model, then
   // advance the model to what the rising edge should do.
   task automatic step(input bit do_rst, input bit rr, output logic [NREQ-1:0] rdy);
      logic [NREQ-1:0] exp_rdy;
      int  g;
      int  c;
      bit  can;
      @(negedge clk);
      rst       = do_rst;
      rsp_ready = rr;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = pend_v[i];
         if (pend_v[i]) begin
            req_a[i*WIDTH +: WIDTH] = WIDTH'(pa[i]);
            req_b[i*WIDTH +: WIDTH] = WIDTH'(pb[i]);
            req_cin[i]              = pc[i];
         end else begin
            req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            req_cin[i]              = 1'($urandom);
         end
      end
      #1;
      rdy = req_ready;
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, model_full});
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         c = (model_ptr + k) % NREQ;
         if (g < 0 && pend_v[c]) g = c;
      end
      can     = !do_rst && (!model_full || rr);
      exp_rdy = (can && g >= 0) ? (NREQ'(1) << g) : '0;
      check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
      if (do_rst) begin
         model_full = 1'b0;
         model_ptr  = 0;
         exp_q.delete();
      end else if (can && g >= 0) begin
         exp_q.push_back('{id: g, sum: pa[g] + pb[g] + int'(pc[g])});
         pend_v[g]  = 1'b0;
         model_ptr  = (g + 1) % NREQ;
         model_full = 1'b1;
      end else if (model_full && rr) begin
         model_full = 1'b0;
      end
   endtask

   // Look at the response registers just after the edge that loaded them.
   task automatic peek_rsp(input string name, input int id, input int s, input bit cout);
      @(posedge clk);
      #1;
      check({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({name, "_id"},    {30'd0, rsp_id},    id);
      check({name, "_s"},     {24'd0, rsp_s},     s);
      check({name, "_cout"},  {31'd0, rsp_cout},  {31'd0, cout});
   endtask

   // Monitor: compare every handed-over response with the scoreboard head, and
   // check that a stalled response does not change.
   initial begin : monitor
      exp_t                  e;
      logic [IDW+WIDTH:0]    held;
      bit                    held_ok;
      held_ok = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst !== 1'b0) begin
            held_ok = 1'b0;
         end else if (rsp_valid === 1'b1) begin
            if (held_ok) begin
               check("rsp_hold", {21'd0, rsp_id, rsp_cout, rsp_s}, {21'd0, held});
            end
            if (rsp_ready) begin
               if (exp_q.size() == 0) begin
                  check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_id",  {30'd0, rsp_id}, e.id);
                  check("rsp_sum", {23'd0, rsp_cout, rsp_s}, e.sum);
               end
               held_ok = 1'b0;
            end else begin
               held    = {rsp_id, rsp_cout, rsp_s};
               held_ok = 1'b1;
            end
         end else begin
            held_ok = 1'b0;
         end
      end
   end

   initial begin : driver
      logic [NREQ-1:0] seq_rdy;
      rst        = 1'b1;
      rsp_ready  = 1'b0;
      req_valid  = '1;
      req_a      = '0;
      req_b      = '0;
      req_cin    = '0;
      model_full = 1'b0;
      model_ptr  = 0;
      for (int i = 0; i < NREQ; i++) begin
         pend_v[i] = 1'b0;
         pa[i]     = 0;
         pb[i]     = 0;
         pc[i]     = 1'b0;
      end

      // 1. Reset held for two edges with every requester valid.
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("t1_req_ready", {28'd0, req_ready}, 32'd0);
      check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("t1_rsp_s",     {24'd0, rsp_s},     32'd0);
      check("t1_rsp_id",    {30'd0, rsp_id},    32'd0);
      check("t1_rsp_cout",  {31'd0, rsp_cout},  32'd0);

      // 2. Single request from requester 1: 200 + 100 + 1 = 301 -> s=45, cout=1.
      set_op(1, 200, 100, 1'b1);
      step(1'b0, 1'b1, got);
      check("t2_grant", {28'd0, got}, 32'h2);
      peek_rsp("t2", 1, 45, 1'b1);
      step(1'b0, 1'b1, got);
      check("t2_no_regrant", {28'd0, got}, 32'h0);

      // 3. All four continuously valid from ptr=0: grants 0,1,2,3,0,1.
      step(1'b1, 1'b1, got);
      for (int j = 0; j < 6; j++) begin
         gen_ops(100);
         step(1'b0, 1'b1, got);
         seq_rdy = NREQ'(1) << (j % NREQ);
         check($sformatf("t3_grant%0d", j), {28'd0, got}, {28'd0, seq_rdy});
      end

      // 4. Backpressure for three cycles, then release: grant resumes at once.
      for (int j = 0; j < 3; j++) begin
         gen_ops(100);
         step(1'b0, 1'b0, got);
         check("t4_stall_ready", {28'd0, got}, 32'h0);
      end
      step(1'b0, 1'b1, got);
      check("t4_release_grant", {28'd0, got}, 32'h4);

      // Let the remaining pending requesters drain.
      repeat (4) step(1'b0, 1'b1, got);

      // 5. Carry and wrap corners through requester 0.
      set_op(0, 255, 0, 1'b1);
      step(1'b0, 1'b1, got);
      peek_rsp("t5a", 0, 0, 1'b1);
      set_op(0, 255, 255, 1'b1);
      step(1'b0, 1'b1, got);
      peek_rsp("t5b", 0, 255, 1'b1);
      set_op(0, 0, 0, 1'b0);
      step(1'b0, 1'b1, got);
      peek_rsp("t5c", 0, 0, 1'b0);

      // 6. Reset while a result is held and requester 2 is waiting.
      set_op(3, 1, 2, 1'b0);
      step(1'b0, 1'b0, got);
      set_op(2, 17, 34, 1'b1);
      step(1'b0, 1'b0, got);
      step(1'b1, 1'b0, got);
      set_op(0, 5, 6, 1'b0);
      set_op(1, 7, 8, 1'b1);
      step(1'b0, 1'b1, got);
      check("t6_first_grant", {28'd0, got}, 32'h1);
      step(1'b0, 1'b1, got);
      check("t6_second_grant", {28'd0, got}, 32'h2);
      step(1'b0, 1'b1, got);
      check("t6_req2_grant", {28'd0, got}, 32'h4);

      // Randomized traffic with random backpressure and occasional reset.
      for (int n = 0; n < 3000; n++) begin
         gen_ops(40);
         step(int'($urandom_range(99)) < 2, int'($urandom_range(99)) < 70, got);
      end

      // Drain: nothing new, consumer always ready.
      repeat (8) step(1'b0, 1'b1, got);
      repeat (2) @(negedge clk);
      #3;
      check("drain_queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
